lfsr_candidate_gen: RTL and testbench
=====================================

LFSR_CANDIDATE_GEN -- requirements
Module: lfsr_candidate_gen

Interface
REQ-001 Parameter NUM_BITS, 128, candidate and LFSR width (min 8).
REQ-002 Parameter TAPS, 128'hA000_0014_0000_0000_0000_0000_0000_0000, Galois right-shift feedback mask, NUM_BITS wide.
REQ-003 Parameter DEFAULT_SEED, 1, LFSR state after reset or after a zero seed load.
REQ-004 Parameter FORCE_MSB, 1, candidate bit NUM_BITS-1 forced to 1 when set.
REQ-005 Parameter FORCE_LSB, 1, candidate bit 0 forced to 1 (odd) when set.
REQ-006 Parameter CNT_W, 16, width of the word-count input and counter.
REQ-007 aclk  in  1  clock, all state on rising edge.
REQ-008 aresetn  in  1  asynchronous active-low reset.
REQ-009 start  in  1  single-cycle request to begin a run; accepted in IDLE or DONE.
REQ-010 stop  in  1  single-cycle abort of a run.
REQ-011 seed_load  in  1  load seed into the LFSR; accepted in IDLE or DONE only.
REQ-012 seed  in  NUM_BITS  seed value.
REQ-013 num_words  in  CNT_W  candidates per run, sampled at start; 0 = continuous.
REQ-014 fifo_full  in  1  downstream FIFO full.
REQ-015 fifo_dout  out  NUM_BITS  candidate word.
REQ-016 fifo_wr_en  out  1  write strobe; a word transfers on each edge where it is 1.
REQ-017 busy  out  1  high in RUN.
REQ-018 o_done  out  1  high while in DONE.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DONE.
REQ-020 Transitions: IDLE/DONE + start -> RUN; RUN + stop -> IDLE; RUN + final write -> DONE; otherwise hold.
REQ-021 fifo_dout SHALL equal lfsr | (FORCE_MSB<<(NUM_BITS-1)) | FORCE_LSB, combinational from the LFSR register.
REQ-022 fifo_wr_en SHALL equal (state==RUN) && !fifo_full && !stop, combinational; never asserted while fifo_full=1.
REQ-023 The LFSR SHALL advance once per write only: next = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0); it holds otherwise.
REQ-024 Throughput SHALL be one candidate per cycle while fifo_full=0; the first write can occur the cycle after start is accepted.
REQ-025 The counter SHALL clear on start acceptance and increment on each write; the write with count==num_words-1 SHALL move to DONE.
REQ-026 num_words=0 SHALL run until stop; the counter wraps modulo 2^CNT_W without effect.
REQ-027 seed_load with seed=0 SHALL load DEFAULT_SEED, so the LFSR never holds zero.
REQ-028 seed_load and start in the same cycle SHALL both take effect; the first candidate uses the new seed.
REQ-029 seed_load, start and num_words changes during RUN SHALL be ignored.
REQ-030 stop in RUN SHALL suppress that cycle's write and return to IDLE; the LFSR keeps its value.
REQ-031 fifo_full high in RUN SHALL stall without losing state; writing resumes the cycle full drops.
REQ-032 stop in IDLE/DONE SHALL be ignored; start in RUN SHALL be ignored.

Reset
REQ-033 aresetn low SHALL immediately force IDLE, lfsr=DEFAULT_SEED, counter=0, fifo_wr_en=0, busy=0, o_done=0, including mid-run.
REQ-034 Deassertion SHALL be synchronised by the environment; the block needs no start before seed_load.

Verification (NUM_BITS=8, TAPS=8'hB8, DEFAULT_SEED=1, FORCE_MSB=FORCE_LSB=1)
REQ-035 Reset, start, num_words=3, fifo_full=0 -> fifo_dout 8'h81, 8'hB9, 8'hDD on three consecutive cycles, then o_done=1, busy=0.
REQ-036 As REQ-035 with fifo_full=1 for 4 cycles after the first write -> wr_en low 4 cycles, then 8'hB9, 8'hDD, no word lost or duplicated.
REQ-037 seed_load seed=0 plus start, num_words=1 -> single write 8'h81; seed_load seed=8'h40 plus start -> single write 8'hC1.
REQ-038 num_words=0, run 255 writes with FORCE_MSB=FORCE_LSB=0 -> all nonzero states distinct, 256th equals the first; stop -> IDLE, no write in the stop cycle.
REQ-039 aresetn pulsed low mid-run (after 2 writes) -> outputs 0 asynchronously; next run restarts at 8'h81.
REQ-040 In DONE: start with num_words=2 -> continues from the held LFSR state, o_done clears, two further writes.

Source files
------------

// File: rtl/lfsr_candidate_gen.sv
// Galois LFSR candidate generator: streams one forced-odd/forced-MSB word per cycle into a FIFO.
// fifo_dout/fifo_wr_en are combinational from state; fifo_full stalls the LFSR and counter in place.
module lfsr_candidate_gen #(
  parameter int                  NUM_BITS     = 128,
  parameter logic [NUM_BITS-1:0] TAPS         = 128'hA000_0014_0000_0000_0000_0000_0000_0000,
  parameter logic [NUM_BITS-1:0] DEFAULT_SEED = NUM_BITS'(1),
  parameter bit                  FORCE_MSB    = 1'b1,
  parameter bit                  FORCE_LSB    = 1'b1,
  parameter int                  CNT_W        = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic                stop,
  input  logic                seed_load,
  input  logic [NUM_BITS-1:0] seed,
  input  logic [CNT_W-1:0]    num_words,
  input  logic                fifo_full,
  output logic [NUM_BITS-1:0] fifo_dout,
  output logic                fifo_wr_en,
  output logic                busy,
  output logic                o_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [NUM_BITS-1:0] FORCE_MASK = {FORCE_MSB, {(NUM_BITS-2){1'b0}}, FORCE_LSB};

  state_t              state;
  logic [NUM_BITS-1:0] lfsr;
  logic [NUM_BITS-1:0] lfsr_adv;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    words_q;
  logic                last_word;

  assign lfsr_adv   = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  assign fifo_dout  = lfsr | FORCE_MASK;
  assign fifo_wr_en = (state == RUN) && !fifo_full && !stop;
  // words_q == 0 means continuous: the counter then just wraps and never ends the run
  assign last_word  = (words_q != '0) && (cnt == words_q - CNT_W'(1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      lfsr    <= DEFAULT_SEED;
      cnt     <= '0;
      words_q <= '0;
      busy    <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // a zero seed would lock the LFSR, so substitute the default
          if (seed_load)
            lfsr <= (seed == '0) ? DEFAULT_SEED : seed;
          if (start) begin
            state   <= RUN;
            cnt     <= '0;
            words_q <= num_words;
            busy    <= 1'b1;
            o_done  <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!fifo_full) begin
            lfsr <= lfsr_adv;
            cnt  <= cnt + CNT_W'(1);
            if (last_word) begin
              state  <= DONE;
              busy   <= 1'b0;
              o_done <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          o_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_candidate_gen.sv
// Scoreboard bench: expected words are queued at run start, a negedge monitor pops on each write.
module tb_lfsr_candidate_gen;

  logic        aclk = 1'b0;
  logic        aresetn, start, stop, seed_load, fifo_full;
  logic [7:0]  seed;
  logic [15:0] num_words;
  logic [7:0]  dout_f, dout_r;
  logic        wr_f, wr_r, busy_f, busy_r, done_f, done_r;

  always #5 aclk = ~aclk;

  lfsr_candidate_gen #(
    .NUM_BITS(8), .TAPS(8'hB8), .DEFAULT_SEED(8'h01),
    .FORCE_MSB(1'b1), .FORCE_LSB(1'b1), .CNT_W(16)
  ) u_dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
    .seed_load(seed_load), .seed(seed), .num_words(num_words), .fifo_full(fifo_full),
    .fifo_dout(dout_f), .fifo_wr_en(wr_f), .busy(busy_f), .o_done(done_f)
  );

  // unforced twin exposes the raw LFSR sequence
  lfsr_candidate_gen #(
    .NUM_BITS(8), .TAPS(8'hB8), .DEFAULT_SEED(8'h01),
    .FORCE_MSB(1'b0), .FORCE_LSB(1'b0), .CNT_W(16)
  ) u_raw (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
    .seed_load(seed_load), .seed(seed), .num_words(num_words), .fifo_full(fifo_full),
    .fifo_dout(dout_r), .fifo_wr_en(wr_r), .busy(busy_r), .o_done(done_r)
  );

  int         nchk = 0;
  int         nerr = 0;
  logic [7:0] q_f[$];
  logic [7:0] q_r[$];
  logic [7:0] log_r[$];
  logic [7:0] m_lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one shift of the Galois register x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] step(input logic [7:0] s);
    logic [7:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 8'hB8;
    return n;
  endfunction

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      q_f.push_back(m_lfsr | 8'h81);
      q_r.push_back(m_lfsr);
      m_lfsr = step(m_lfsr);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (fifo_full) check("wr_en_while_full", 32'(wr_f), 32'd0);
      if (wr_f) begin
        check("write_expected", 32'(q_f.size() != 0), 32'd1);
        if (q_f.size() != 0) check("word", 32'(dout_f), 32'(q_f.pop_front()));
        if (q_r.size() != 0) check("raw_word", 32'(dout_r), 32'(q_r.pop_front()));
        log_r.push_back(dout_r);
      end
    end
  end

  task automatic run(input int nw, input bit ld, input logic [7:0] sd, input bit stall,
                     input string tag);
    int cyc;
    if (ld) begin
      seed_load = 1'b1;
      seed      = sd;
      m_lfsr    = (sd == 8'h00) ? 8'h01 : sd;
    end
    num_words = 16'(nw);
    start     = 1'b1;
    push_words(nw);
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy_f), 32'd1);
    check({tag, "_done_after_start"}, 32'(done_f), 32'd0);
    cyc = 0;
    while (cyc < 400 && !done_f) begin
      fifo_full = stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      // inputs that must be ignored while a run is in progress
      if (stall && busy_f && $urandom_range(0, 3) == 0) begin
        start     = 1'b1;
        seed_load = 1'b1;
        seed      = 8'($urandom);
        num_words = 16'($urandom);
      end else begin
        start     = 1'b0;
        seed_load = 1'b0;
      end
      tick();
      cyc++;
    end
    start     = 1'b0;
    seed_load = 1'b0;
    fifo_full = 1'b0;
    if (!stall) check({tag, "_cycles"}, 32'(cyc), 32'(nw));
    check({tag, "_done"}, 32'(done_f), 32'd1);
    check({tag, "_busy_end"}, 32'(busy_f), 32'd0);
    check({tag, "_words_left"}, 32'(q_f.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", nchk);
    $fatal(1);
  end

  initial begin
    logic [7:0] rs;
    bit         seen[256];
    int         distinct;
    aresetn = 1'b0; start = 1'b0; stop = 1'b0; seed_load = 1'b0;
    fifo_full = 1'b0; seed = 8'h00; num_words = 16'd0;
    m_lfsr = 8'h01;
    #12;
    check("rst_dout", 32'(dout_f), 32'h81);
    check("rst_raw", 32'(dout_r), 32'h01);
    check("rst_wr", 32'(wr_f), 32'd0);
    check("rst_busy", 32'(busy_f), 32'd0);
    check("rst_done", 32'(done_f), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();

    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_idle_busy", 32'(busy_f), 32'd0);

    run(3, 1'b0, 8'h00, 1'b0, "basic3");
    run(2, 1'b0, 8'h00, 1'b0, "from_done");

    // stall for 4 cycles after the first write
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    q_f.delete(); q_r.delete(); m_lfsr = 8'h01;
    num_words = 16'd3;
    start = 1'b1;
    push_words(3);
    tick();
    start = 1'b0;
    tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_wr", 32'(wr_f), 32'd0);
      check("stall_busy", 32'(busy_f), 32'd1);
      tick();
    end
    fifo_full = 1'b0;
    for (int i = 0; i < 20 && !done_f; i++) tick();
    check("stall_done", 32'(done_f), 32'd1);
    check("stall_words_left", 32'(q_f.size()), 32'd0);

    run(1, 1'b1, 8'h00, 1'b0, "seed_zero");
    run(1, 1'b1, 8'h40, 1'b0, "seed_40");

    seed_load = 1'b1;
    seed = 8'h5A;
    tick();
    seed_load = 1'b0;
    m_lfsr = 8'h5A;
    check("seed_only_dout", 32'(dout_f), 32'hDB);

    repeat (12) begin
      rs = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      run($urandom_range(1, 6), 1'($urandom_range(0, 1)), rs, 1'b1, "rand");
    end

    // asynchronous reset after two writes of a five-word run
    num_words = 16'd5;
    start = 1'b1;
    push_words(5);
    tick();
    start = 1'b0;
    tick();
    tick();
    aresetn = 1'b0;
    #1;
    check("arst_wr", 32'(wr_f), 32'd0);
    check("arst_busy", 32'(busy_f), 32'd0);
    check("arst_done", 32'(done_f), 32'd0);
    check("arst_dout", 32'(dout_f), 32'h81);
    check("arst_words_left", 32'(q_f.size()), 32'd3);
    q_f.delete(); q_r.delete(); m_lfsr = 8'h01;
    @(negedge aclk);
    #1;
    aresetn = 1'b1;
    tick();
    run(2, 1'b0, 8'h00, 1'b0, "after_arst");

    // continuous run of 256 writes, then stop
    log_r.delete();
    num_words = 16'd0;
    start = 1'b1;
    push_words(256);
    tick();
    start = 1'b0;
    repeat (256) tick();
    check("cont_busy", 32'(busy_f), 32'd1);
    check("cont_words_left", 32'(q_f.size()), 32'd0);
    check("cont_log_len", 32'(log_r.size()), 32'd256);
    stop = 1'b1;
    #1;
    check("stop_suppress_wr", 32'(wr_f), 32'd0);
    tick();
    stop = 1'b0;
    check("stop_busy", 32'(busy_f), 32'd0);
    check("stop_done", 32'(done_f), 32'd0);
    check("stop_lfsr_held", 32'(dout_r), 32'(m_lfsr));
    tick();
    check("stop_no_write", 32'(log_r.size()), 32'd256);
    if (log_r.size() == 256) begin
      distinct = 0;
      for (int i = 0; i < 255; i++) begin
        if (log_r[i] != 8'h00 && !seen[log_r[i]]) distinct++;
        seen[log_r[i]] = 1'b1;
      end
      check("period_distinct", 32'(distinct), 32'd255);
      check("period_wrap", 32'(log_r[255]), 32'(log_r[0]));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
